// File: rtl/eth_sw_pkg.sv
// Shared types and constants for the two-port word-stream switch.
// The flit field `last` carries the frame end flag ("end" is a reserved word).
package eth_sw_pkg;

  localparam logic [31:0] DEF_PORTA_ADDR = 32'h0000_ABCD;
  localparam logic [31:0] DEF_PORTB_ADDR = 32'h0000_BEEF;

  typedef struct packed {
    logic [31:0] data;
    logic        start;
    logic        last;
  } word_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

  function automatic port_e port_of(input int idx);
    return (idx == 1) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/eth_sw_fifo.sv
// Synchronous word FIFO with registered count and full/empty flags.
// The head word is presented combinationally; it is meaningful only while not empty.
module eth_sw_fifo
  import eth_sw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  word_t                  wr_data_i,
  input  logic                   rd_en_i,
  output word_t                  rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]       CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]     PTR_ONE  = AW'(1);

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          wr_ok;
  logic          rd_ok;

  // A write into a full FIFO is dropped, even if a read frees a slot that cycle.
  assign wr_ok = wr_en_i && !full_q;
  assign rd_ok = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      full_q  <= (count_d == FULL_CNT);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/eth_sw_modport.sv
// Two-port word-stream switch: input framing and FIFOs, DA route decode,
// and one round-robin frame arbiter per output with registered outputs.
module eth_sw_modport
  import eth_sw_pkg::*;
#(
  parameter logic [31:0] PORTA_ADDR = DEF_PORTA_ADDR,
  parameter logic [31:0] PORTB_ADDR = DEF_PORTB_ADDR,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] i_dataA,
  input  logic [31:0] i_dataB,
  input  logic        i_startA,
  input  logic        i_startB,
  input  logic        i_endA,
  input  logic        i_endB,
  output logic [31:0] o_dataA,
  output logic [31:0] o_dataB,
  output logic        o_startA,
  output logic        o_startB,
  output logic        o_endA,
  output logic        o_endB,
  output logic        portA_stall,
  output logic        portB_stall
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_TH = CW'(FIFO_DEPTH - 2);

  logic          rst;
  logic [31:0]   in_data    [2];
  logic          in_start   [2];
  logic          in_end     [2];
  logic          in_frame_q [2];
  logic          in_frame_d [2];
  logic          in_vld_q   [2];
  logic          in_vld_d   [2];
  word_t         in_word_q  [2];
  word_t         in_word_d  [2];
  word_t         head       [2];
  logic          empty      [2];
  logic [CW-1:0] cnt        [2];
  logic          pop        [2];
  logic          route_vld  [2];
  port_e         route_port [2];
  logic          owned      [2];
  logic          req        [2][2];
  port_e         win        [2];
  arb_state_e    arb_q      [2];
  arb_state_e    arb_d      [2];
  port_e         own_q      [2];
  port_e         own_d      [2];
  port_e         rr_q       [2];
  port_e         rr_d       [2];
  word_t         fwd_word   [2];
  word_t         out_q      [2];

  // Despite its name, rstn is an active-high asynchronous reset.
  assign rst = rstn;

  assign in_data[0]  = i_dataA;
  assign in_data[1]  = i_dataB;
  assign in_start[0] = i_startA;
  assign in_start[1] = i_startB;
  assign in_end[0]   = i_endA;
  assign in_end[1]   = i_endB;

  // A start flag inside a frame is stored as plain data so heads stay trustworthy.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_frame_d[p] = in_frame_q[p];
      in_vld_d[p]   = in_frame_q[p] || in_start[p];
      in_word_d[p]  = '{data: in_data[p], start: in_start[p] && !in_frame_q[p], last: in_end[p]};
      if (in_vld_d[p]) in_frame_d[p] = !in_end[p];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        in_frame_q[p] <= 1'b0;
        in_vld_q[p]   <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        in_frame_q[p] <= in_frame_d[p];
        in_vld_q[p]   <= in_vld_d[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) in_word_q[p] <= in_word_d[p];
  end

  eth_sw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_vld_q[0]),
    .wr_data_i (in_word_q[0]),
    .rd_en_i   (pop[0]),
    .rd_data_o (head[0]),
    .count_o   (cnt[0]),
    .empty_o   (empty[0])
  );

  eth_sw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_vld_q[1]),
    .wr_data_i (in_word_q[1]),
    .rd_en_i   (pop[1]),
    .rd_data_o (head[1]),
    .count_o   (cnt[1]),
    .empty_o   (empty[1])
  );

  assign portA_stall = (cnt[0] >= STALL_TH);
  assign portB_stall = (cnt[1] >= STALL_TH);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      route_vld[p]  = head[p].start &&
                      ((head[p].data == PORTA_ADDR) || (head[p].data == PORTB_ADDR));
      route_port[p] = (head[p].data == PORTA_ADDR) ? PORT_A : PORT_B;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pop[p]   = 1'b0;
      owned[p] = 1'b0;
    end
    for (int o = 0; o < 2; o++) begin
      arb_d[o]    = arb_q[o];
      own_d[o]    = own_q[o];
      rr_d[o]     = rr_q[o];
      win[o]      = PORT_A;
      fwd_word[o] = '0;
      for (int p = 0; p < 2; p++) begin
        req[o][p] = !empty[p] && route_vld[p] && (route_port[p] == port_of(o));
        if ((arb_q[o] == ARB_BUSY) && (own_q[o] == port_of(p))) owned[p] = 1'b1;
      end
    end

    for (int o = 0; o < 2; o++) begin
      if (arb_q[o] == ARB_IDLE) begin
        if (req[o][0] && req[o][1]) win[o] = rr_q[o];
        else if (req[o][1])         win[o] = PORT_B;
        if (req[o][0] || req[o][1]) begin
          fwd_word[o]  = head[win[o]];
          pop[win[o]]  = 1'b1;
          own_d[o]     = win[o];
          rr_d[o]      = other_port(win[o]);
          if (!head[win[o]].last) arb_d[o] = ARB_BUSY;
        end
      end else if (!empty[own_q[o]]) begin
        fwd_word[o]    = head[own_q[o]];
        pop[own_q[o]]  = 1'b1;
        if (head[own_q[o]].last) arb_d[o] = ARB_IDLE;
      end
    end

    // Unroutable starts and any unowned non-start words are drained one per cycle.
    for (int p = 0; p < 2; p++) begin
      if (!empty[p] && !owned[p] && !route_vld[p]) pop[p] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < 2; o++) begin
        arb_q[o] <= ARB_IDLE;
        own_q[o] <= PORT_A;
        rr_q[o]  <= PORT_A;
        out_q[o] <= '0;
      end
    end else begin
      for (int o = 0; o < 2; o++) begin
        arb_q[o] <= arb_d[o];
        own_q[o] <= own_d[o];
        rr_q[o]  <= rr_d[o];
        out_q[o] <= fwd_word[o];
      end
    end
  end

  assign o_dataA  = out_q[0].data;
  assign o_startA = out_q[0].start;
  assign o_endA   = out_q[0].last;
  assign o_dataB  = out_q[1].data;
  assign o_startB = out_q[1].start;
  assign o_endB   = out_q[1].last;

endmodule

// File: tb/tb_eth_sw_modport.sv
// Scoreboard bench for eth_sw_modport: directed frames push expected output
// words (with arrival cycle) into per-output queues; a negedge monitor pops and compares.
module tb_eth_sw_modport;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] i_dataA = '0;
  logic [31:0] i_dataB = '0;
  logic        i_startA = 1'b0;
  logic        i_startB = 1'b0;
  logic        i_endA = 1'b0;
  logic        i_endB = 1'b0;
  logic [31:0] o_dataA;
  logic [31:0] o_dataB;
  logic        o_startA;
  logic        o_startB;
  logic        o_endA;
  logic        o_endB;
  logic        portA_stall;
  logic        portB_stall;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        s;
    logic        e;
    int          at;
  } exp_t;

  exp_t expA[$];
  exp_t expB[$];

  eth_sw_modport dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_dataA     (i_dataA),
    .i_dataB     (i_dataB),
    .i_startA    (i_startA),
    .i_startB    (i_startB),
    .i_endA      (i_endA),
    .i_endB      (i_endB),
    .o_dataA     (o_dataA),
    .o_dataB     (o_dataB),
    .o_startA    (o_startA),
    .o_startB    (o_startB),
    .o_endA      (o_endA),
    .o_endB      (o_endB),
    .portA_stall (portA_stall),
    .portB_stall (portB_stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int port, input logic [31:0] d, input logic s, input logic e,
                      input int at);
    exp_t x;
    x.data = d;
    x.s    = s;
    x.e    = e;
    x.at   = at;
    if (port == 0) expA.push_back(x);
    else           expB.push_back(x);
  endtask

  task automatic mon(input int port, input logic [31:0] d, input logic s, input logic e);
    exp_t x;
    bit   have;
    if (d == 32'h0 && !s && !e) return;
    have = 1'b0;
    if (port == 0 && expA.size() > 0) begin x = expA.pop_front(); have = 1'b1; end
    if (port == 1 && expB.size() > 0) begin x = expB.pop_front(); have = 1'b1; end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected_out%s @%0d: got data=%h start=%b end=%b, required no output",
               (port == 0) ? "A" : "B", cyc, d, s, e);
    end else if (d !== x.data || s !== x.s || e !== x.e || cyc != x.at) begin
      errors++;
      $display("FAIL out%s: got data=%h start=%b end=%b cycle=%0d, required data=%h start=%b end=%b cycle=%0d",
               (port == 0) ? "A" : "B", d, s, e, cyc, x.data, x.s, x.e, x.at);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      mon(0, o_dataA, o_startA, o_endA);
      mon(1, o_dataB, o_startB, o_endB);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] da, input logic sa, input logic ea,
                       input logic [31:0] db, input logic sb, input logic eb);
    @(posedge clk);
    #1;
    i_dataA  = da;
    i_startA = sa;
    i_endA   = ea;
    i_dataB  = db;
    i_startB = sb;
    i_endB   = eb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string nm);
    int w;
    w = 0;
    while ((expA.size() > 0 || expB.size() > 0) && w < 200) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (expA.size() > 0 || expB.size() > 0) begin
      errors++;
      $display("FAIL %s: got %0d/%0d words still pending, required 0/0",
               nm, expA.size(), expB.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1 [4];
    logic [31:0] wa;
    logic [31:0] wb;
    int k;

    t1[0] = 32'h0000_BEEF;
    t1[1] = 32'h0000_ABCD;
    t1[2] = 32'h0000_1111;
    t1[3] = 32'h0000_2222;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_o_dataA", o_dataA, 32'h0);
    chk("reset_o_dataB", o_dataB, 32'h0);
    chkb("reset_o_startA", o_startA, 1'b0);
    chkb("reset_o_endB", o_endB, 1'b0);
    chkb("reset_stallA", portA_stall, 1'b0);
    chkb("reset_stallB", portB_stall, 1'b0);
    rstn = 1'b0;
    idle(2);

    // A -> B, 4 words
    for (int i = 0; i < 4; i++) begin
      drive(t1[i], i == 0, i == 3, 32'h0, 1'b0, 1'b0);
      push(1, t1[i], i == 0, i == 3, cyc + 3);
    end
    idle(6);

    // A -> B and B -> A concurrently
    for (int i = 0; i < 5; i++) begin
      wa = (i == 0) ? 32'h0000_BEEF : (32'h3300_0000 | 32'(i));
      wb = (i == 0) ? 32'h0000_ABCD : (32'h5500_0000 | 32'(i));
      drive((i < 4) ? wa : 32'h0, i == 0, i == 3, wb, i == 0, i == 4);
      if (i < 4) push(1, wa, i == 0, i == 3, cyc + 3);
      push(0, wb, i == 0, i == 4, cyc + 3);
      chkb("cross_stallA", portA_stall, 1'b0);
      chkb("cross_stallB", portB_stall, 1'b0);
    end
    idle(6);

    // A (8 words) and B (6 words) both to output A in the same cycle
    k = 0;
    for (int i = 0; i < 8; i++) begin
      wa = (i == 0) ? 32'h0000_ABCD : (32'hA000_0000 | 32'(i));
      wb = (i == 0) ? 32'h0000_ABCD : (32'hB000_0000 | 32'(i));
      drive(wa, i == 0, i == 7, (i < 6) ? wb : 32'h0, i == 0, i == 5);
      if (i == 0) k = cyc;
      push(0, wa, i == 0, i == 7, k + 3 + i);
      if (i == 5) chkb("contend_stallB_early", portB_stall, 1'b0);
      if (i == 7) chkb("contend_stallB_full", portB_stall, 1'b1);
      if (i == 7) chkb("contend_stallA", portA_stall, 1'b0);
    end
    for (int j = 0; j < 6; j++) begin
      wb = (j == 0) ? 32'h0000_ABCD : (32'hB000_0000 | 32'(j));
      push(0, wb, j == 0, j == 5, k + 11 + j);
    end
    idle(14);

    // Unknown DA frame is drained, then a one-word frame right behind it
    for (int i = 0; i < 4; i++) begin
      wa = (i == 0) ? 32'h0000_1234 : (32'hAAAA_0000 | 32'(i));
      drive(wa, i == 0, i == 3, 32'h0, 1'b0, 1'b0);
    end
    drive(32'h0000_BEEF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    push(1, 32'h0000_BEEF, 1'b1, 1'b1, cyc + 3);
    idle(6);
    wait_drain("drain_after_unknown_da");

    // A's frame blocked behind B's long frame on output A; A's FIFO overflows
    k = 0;
    for (int i = 0; i < 15; i++) begin
      wb = (i == 0) ? 32'h0000_ABCD : (32'hC000_0000 | 32'(i));
      wa = (i == 1) ? 32'h0000_ABCD : (32'hD000_0000 | 32'(i - 1));
      drive((i >= 1 && i <= 10) ? wa : 32'h0, i == 1, i == 10,
            (i < 14) ? wb : 32'h0, i == 0, i == 13);
      if (i == 0) k = cyc;
      if (i < 14) push(0, wb, i == 0, i == 13, k + 3 + i);
      if (i == 6) chkb("burst_stallA_below", portA_stall, 1'b0);
      if (i == 9) chkb("burst_stallA_high", portA_stall, 1'b1);
      if (i == 9) chkb("burst_stallB", portB_stall, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      wa = (j == 0) ? 32'h0000_ABCD : (32'hD000_0000 | 32'(j));
      push(0, wa, j == 0, 1'b0, k + 17 + j);
    end
    wait_drain("drain_after_burst");
    idle(4);

    // Reset pulse while a B -> B frame is leaving the output register
    for (int i = 0; i < 4; i++) begin
      wb = (i == 0) ? 32'h0000_BEEF : (32'hE000_0000 | 32'(i));
      drive(32'h0, 1'b0, 1'b0, wb, i == 0, 1'b0);
    end
    #1;
    chk("midframe_o_dataB", o_dataB, 32'h0000_BEEF);
    rstn = 1'b1;
    #1;
    chk("rst_async_o_dataB", o_dataB, 32'h0);
    chkb("rst_async_o_startB", o_startB, 1'b0);
    chk("rst_async_o_dataA", o_dataA, 32'h0);
    rstn = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 32'hE000_0004, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 32'hE000_0005, 1'b0, 1'b1);
    idle(4);
    chkb("post_rst_stallB", portB_stall, 1'b0);

    // Fresh frames after reset: A -> A and B -> B
    for (int i = 0; i < 3; i++) begin
      wa = (i == 0) ? 32'h0000_ABCD : (32'hF100_0000 | 32'(i));
      wb = (i == 0) ? 32'h0000_BEEF : (32'hF200_0000 | 32'(i));
      drive(wa, i == 0, i == 2, wb, i == 0, i == 2);
      push(0, wa, i == 0, i == 2, cyc + 3);
      push(1, wb, i == 0, i == 2, cyc + 3);
    end
    idle(6);
    wait_drain("drain_final");
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
